// File: rtl/uart_word_bridge_pkg.sv
// uart_word_bridge_pkg: shared byte width, RX/TX state encodings and index sizing helper.
// Rev 1.0
`default_nettype none

package uart_word_bridge_pkg;

  localparam int N_BIT_DEF = 8;

  typedef enum logic [0:0] {
    R_COLLECT = 1'b0,
    R_DELIVER = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_SEND = 2'd1,
    T_DONE = 2'd2
  } tx_state_e;

  // A one-byte word still needs a 1-bit index so the lane logic stays uniform.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_word_bridge_if.sv
// uart_word_bridge_if: UART FIFO side (RX pop, TX push) seen by the word bridge.
// Rev 1.0
`default_nettype none

interface uart_word_bridge_if
  import uart_word_bridge_pkg::*;
#(
  parameter int N_BIT = N_BIT_DEF
);

  logic             rx_empty;
  logic [N_BIT-1:0] r_data;
  logic             rd_uart;
  logic             tx_full;
  logic             wr_uart;
  logic [N_BIT-1:0] w_data;

  modport master (
    input  rx_empty, r_data, tx_full,
    output rd_uart, wr_uart, w_data
  );

  modport slave (
    output rx_empty, r_data, tx_full,
    input  rd_uart, wr_uart, w_data
  );

endinterface

`default_nettype wire

// File: rtl/uart_word_bridge_rx.sv
// uart_word_rx: pops show-ahead RX FIFO bytes into little-endian words, dropping stale partials.
// Rev 1.0
`default_nettype none

module uart_word_rx
  import uart_word_bridge_pkg::*;
#(
  parameter int N_BIT       = N_BIT_DEF,
  parameter int N_BYTES     = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_BIT     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_empty,
  input  logic [N_BIT-1:0]         r_data,
  output logic                     rd_uart,
  output logic [N_BIT*N_BYTES-1:0] rx_word,
  output logic                     rx_valid,
  output logic                     rx_timeout
);

  localparam int               IDX_W    = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [CNT_BIT-1:0] TO_LAST = CNT_BIT'(TIMEOUT_CYC - 1);
  localparam bit               TO_EN    = (TIMEOUT_CYC != 0);

  rx_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_BIT-1:0]              timer_q, timer_d;
  logic [N_BYTES-1:0][N_BIT-1:0]   lanes_q, lanes_d;
  logic [N_BIT*N_BYTES-1:0]        rx_word_q, rx_word_d;
  logic                            rx_valid_q, rx_valid_d;
  logic                            rx_timeout_q, rx_timeout_d;
  logic                            pop;

  assign pop     = (state_q == R_COLLECT) && !rx_empty;
  assign rd_uart = pop;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    lanes_d      = lanes_q;
    rx_word_d    = rx_word_q;
    rx_valid_d   = 1'b0;
    rx_timeout_d = 1'b0;
    case (state_q)
      R_COLLECT: begin
        if (pop) begin
          lanes_d[idx_q] = r_data;
          timer_d        = '0;
          if (idx_q == LAST_IDX) begin
            rx_word_d  = lanes_d;
            rx_valid_d = 1'b1;
            idx_d      = '0;
            state_d    = R_DELIVER;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (idx_q == '0 || !TO_EN) begin
          timer_d = '0;
        end else if (rx_empty) begin
          // Partial word has gone quiet for too long: drop it, keep the last good word.
          if (timer_q == TO_LAST) begin
            idx_d        = '0;
            timer_d      = '0;
            rx_timeout_d = 1'b1;
          end else begin
            timer_d = timer_q + CNT_BIT'(1);
          end
        end
      end
      default: begin
        state_d = R_COLLECT;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= R_COLLECT;
      idx_q        <= '0;
      timer_q      <= '0;
      lanes_q      <= '0;
      rx_word_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      lanes_q      <= lanes_d;
      rx_word_q    <= rx_word_d;
      rx_valid_q   <= rx_valid_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign rx_word    = rx_word_q;
  assign rx_valid   = rx_valid_q;
  assign rx_timeout = rx_timeout_q;

endmodule

`default_nettype wire

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: word-level client of the UART FIFOs; RX word assembly plus inline TX serializer.
// Rev 1.0
`default_nettype none

module uart_word_bridge
  import uart_word_bridge_pkg::*;
#(
  parameter int N_BIT       = N_BIT_DEF,
  parameter int N_BYTES     = 2,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_BIT     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_word_bridge_if.master       fifo,
  input  logic [N_BIT*N_BYTES-1:0] tx_word,
  input  logic                     tx_send,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [N_BIT*N_BYTES-1:0] rx_word,
  output logic                     rx_valid,
  output logic                     rx_timeout
);

  localparam int               W        = N_BIT * N_BYTES;
  localparam int               IDX_W    = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  uart_word_rx #(
    .N_BIT       (N_BIT),
    .N_BYTES     (N_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_BIT     (CNT_BIT)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_empty   (fifo.rx_empty),
    .r_data     (fifo.r_data),
    .rd_uart    (fifo.rd_uart),
    .rx_word    (rx_word),
    .rx_valid   (rx_valid),
    .rx_timeout (rx_timeout)
  );

  tx_state_e        tx_state_q, tx_state_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [W-1:0]     shift_q, shift_d;
  logic             tx_busy_q, tx_busy_d;
  logic             tx_done_q, tx_done_d;
  logic             push;

  assign push         = (tx_state_q == T_SEND) && !fifo.tx_full;
  assign fifo.wr_uart = push;
  assign fifo.w_data  = shift_q[N_BIT-1:0];

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    shift_d    = shift_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_send) begin
          shift_d    = tx_word;
          tx_idx_d   = '0;
          tx_busy_d  = 1'b1;
          tx_state_d = T_SEND;
        end
      end
      T_SEND: begin
        // A full TX FIFO simply freezes the serializer where it is.
        if (push) begin
          shift_d = shift_q >> N_BIT;
          if (tx_idx_q == LAST_IDX) begin
            tx_done_d  = 1'b1;
            tx_state_d = T_DONE;
          end else begin
            tx_idx_d = tx_idx_q + IDX_W'(1);
          end
        end
      end
      T_DONE: begin
        tx_busy_d  = 1'b0;
        tx_state_d = T_IDLE;
      end
      default: begin
        tx_busy_d  = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_idx_q   <= '0;
      shift_q    <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_idx_q   <= tx_idx_d;
      shift_q    <= shift_d;
      tx_busy_q  <= tx_busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_bridge.sv
// tb_uart_word_bridge: drives uart_word_bridge from queue-based FIFO models and checks words/bytes.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_uart_word_bridge;

  localparam int N_BIT       = 8;
  localparam int N_BYTES     = 2;
  localparam int W           = N_BIT * N_BYTES;
  localparam int TIMEOUT_CYC = 100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tx_word = '0;
  logic         tx_send = 1'b0;
  logic         tx_busy, tx_done, rx_valid, rx_timeout;
  logic [W-1:0] rx_word;

  uart_word_bridge_if #(.N_BIT(N_BIT)) fifo_if ();

  uart_word_bridge #(
    .N_BIT       (N_BIT),
    .N_BYTES     (N_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_BIT     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo       (fifo_if),
    .tx_word    (tx_word),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .rx_word    (rx_word),
    .rx_valid   (rx_valid),
    .rx_timeout (rx_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rxq[$];
  int          rd_cyc[$];
  logic [7:0]  txlog[$];
  int          wr_cyc[$];
  logic [15:0] words[$];
  int          valid_cyc[$];
  int          to_cyc[$];
  int          done_cyc[$];
  bit          rd_seen = 1'b0;

  // FIFO models: inputs change on the falling edge, observations 1ns later.
  initial begin
    fifo_if.rx_empty = 1'b1;
    fifo_if.r_data   = '0;
    fifo_if.tx_full  = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_seen && rxq.size() > 0) rxq.delete(0);
      fifo_if.rx_empty = (rxq.size() == 0);
      fifo_if.r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
      #1;
      rd_seen = fifo_if.rd_uart;
      if (fifo_if.rd_uart) rd_cyc.push_back(cyc);
      if (fifo_if.wr_uart) begin
        txlog.push_back(fifo_if.w_data);
        wr_cyc.push_back(cyc);
      end
      if (rx_valid) begin
        words.push_back(rx_word);
        valid_cyc.push_back(cyc);
      end
      if (rx_timeout) to_cyc.push_back(cyc);
      if (tx_done) done_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_cyc.delete();
    txlog.delete();
    wr_cyc.delete();
    words.delete();
    valid_cyc.delete();
    to_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    logic [63:0] v;
    int          guard;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    v = {fifo_if.rd_uart, fifo_if.wr_uart, fifo_if.w_data, rx_word, rx_valid, rx_timeout, tx_busy, tx_done};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 0", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    rxq.push_back(8'h34);
    guard = 0;
    while (rd_cyc.size() < 1 && guard < 10) begin
      @(negedge clk);
      #2;
      guard++;
    end
    tests++;
    if (rd_cyc.size() != 1) begin
      fails++;
      $display("FAIL reset_first_pop: got %0d pops, expected 1", rd_cyc.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    v = {fifo_if.rd_uart, fifo_if.wr_uart, fifo_if.w_data, rx_word, rx_valid, rx_timeout, tx_busy, tx_done};
    tests++;
    if (v !== '0) begin
      fails++;
      $display("FAIL reset_midword_outputs: got %h, expected 0", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    rxq.push_back(8'h34);
    rxq.push_back(8'h12);
    run_cycles(10);
    tests++;
    if (words.size() != 1 || words[0] !== 16'h1234) begin
      fails++;
      $display("FAIL reset_no_stale: got %0d words first %h, expected 1 word 1234", words.size(), words[0]);
    end
  endtask

  task automatic test_rx_assembly();
    clear_logs();
    @(negedge clk);
    rxq.push_back(8'h34);
    rxq.push_back(8'h12);
    run_cycles(10);
    tests++;
    if (rd_cyc.size() != 2 || rd_cyc[1] != rd_cyc[0] + 1) begin
      fails++;
      $display("FAIL rx_pop_cycles: got %0d pops, expected 2 consecutive", rd_cyc.size());
    end
    tests++;
    if (valid_cyc.size() != 1 || valid_cyc[0] != rd_cyc[1] + 1) begin
      fails++;
      $display("FAIL rx_valid_timing: got %0d pulses at %0d, expected 1 at %0d",
               valid_cyc.size(), valid_cyc[0], rd_cyc[1] + 1);
    end
    tests++;
    if (words.size() != 1 || words[0] !== 16'h1234) begin
      fails++;
      $display("FAIL rx_word: got %h, expected 1234", words[0]);
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    @(negedge clk);
    rxq.push_back(8'hAB);
    run_cycles(130);
    tests++;
    if (rd_cyc.size() != 1 || to_cyc.size() != 1 || to_cyc[0] != rd_cyc[0] + TIMEOUT_CYC + 1) begin
      fails++;
      $display("FAIL timeout_cycle: got %0d pulses at %0d, expected 1 at %0d",
               to_cyc.size(), to_cyc[0], rd_cyc[0] + TIMEOUT_CYC + 1);
    end
    tests++;
    if (valid_cyc.size() != 0 || rx_word !== 16'h1234) begin
      fails++;
      $display("FAIL timeout_no_valid: got %0d valids, rx_word %h, expected 0 and 1234",
               valid_cyc.size(), rx_word);
    end
    @(negedge clk);
    rxq.push_back(8'h78);
    rxq.push_back(8'h56);
    run_cycles(10);
    tests++;
    if (words.size() != 1 || words[0] !== 16'h5678 || to_cyc.size() != 1) begin
      fails++;
      $display("FAIL timeout_recover: got %0d words first %h, expected 1 word 5678", words.size(), words[0]);
    end
  endtask

  task automatic test_tx_backpressure();
    clear_logs();
    @(negedge clk);
    fifo_if.tx_full = 1'b1;
    tx_word = 16'hBEEF;
    tx_send = 1'b1;
    @(negedge clk);
    tx_send = 1'b0;
    tx_word = '0;
    repeat (4) @(negedge clk);
    #2;
    tests++;
    if (wr_cyc.size() != 0 || tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL tx_stall: got %0d pushes busy=%b, expected 0 pushes busy=1", wr_cyc.size(), tx_busy);
    end
    @(negedge clk);
    fifo_if.tx_full = 1'b0;
    run_cycles(10);
    tests++;
    if (txlog.size() != 2 || txlog[0] !== 8'hEF || txlog[1] !== 8'hBE) begin
      fails++;
      $display("FAIL tx_bytes: got %0d bytes %h %h, expected EF BE", txlog.size(), txlog[0], txlog[1]);
    end
    tests++;
    if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[1] + 1 || tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL tx_done: got %0d pulses at %0d busy=%b, expected 1 at %0d busy=0",
               done_cyc.size(), done_cyc[0], tx_busy, wr_cyc[1] + 1);
    end
  endtask

  task automatic test_tx_ignore();
    clear_logs();
    @(negedge clk);
    tx_word = 16'hBEEF;
    tx_send = 1'b1;
    rxq.push_back(8'hFE);
    rxq.push_back(8'hCA);
    @(negedge clk);
    tx_word = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    tx_send = 1'b0;
    tx_word = '0;
    run_cycles(10);
    tests++;
    if (txlog.size() != 2 || txlog[0] !== 8'hEF || txlog[1] !== 8'hBE || done_cyc.size() != 1) begin
      fails++;
      $display("FAIL tx_ignore: got %0d bytes %h %h, expected EF BE only", txlog.size(), txlog[0], txlog[1]);
    end
    tests++;
    if (words.size() != 1 || words[0] !== 16'hCAFE) begin
      fails++;
      $display("FAIL rx_concurrent: got %0d words first %h, expected CAFE", words.size(), words[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    @(negedge clk);
    rxq.push_back(8'h01);
    rxq.push_back(8'h02);
    rxq.push_back(8'h03);
    rxq.push_back(8'h04);
    run_cycles(15);
    tests++;
    if (words.size() != 2 || words[0] !== 16'h0201 || words[1] !== 16'h0403) begin
      fails++;
      $display("FAIL b2b_words: got %0d words %h %h, expected 0201 0403", words.size(), words[0], words[1]);
    end
    tests++;
    if (valid_cyc.size() != 2 || valid_cyc[1] - valid_cyc[0] != 3) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d pulses gap %0d, expected 2 gap 3",
               valid_cyc.size(), valid_cyc[1] - valid_cyc[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_rx[$];
    logic [7:0]  exp_tx[$];
    clear_logs();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] w;
          w = 16'($urandom);
          exp_rx.push_back(w);
          @(negedge clk);
          rxq.push_back(w[7:0]);
          repeat ($urandom_range(0, 4)) @(negedge clk);
          rxq.push_back(w[15:8]);
          repeat ($urandom_range(1, 6)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          logic [15:0] w;
          int          guard;
          w = 16'($urandom);
          exp_tx.push_back(w[7:0]);
          exp_tx.push_back(w[15:8]);
          @(negedge clk);
          guard = 0;
          while (tx_busy && guard < 100) begin
            @(negedge clk);
            guard++;
          end
          tx_word = w;
          tx_send = 1'b1;
          fifo_if.tx_full = ($urandom_range(0, 2) == 0);
          @(negedge clk);
          tx_send = 1'b0;
          guard = 0;
          while (tx_busy && guard < 100) begin
            fifo_if.tx_full = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            guard++;
          end
        end
        fifo_if.tx_full = 1'b0;
      end
    join
    run_cycles(30);
    tests++;
    if (words.size() != exp_rx.size()) begin
      fails++;
      $display("FAIL rand_rx_count: got %0d words, expected %0d", words.size(), exp_rx.size());
    end
    for (int i = 0; i < exp_rx.size(); i++) begin
      tests++;
      if (words[i] !== exp_rx[i]) begin
        fails++;
        $display("FAIL rand_rx_word[%0d]: got %h, expected %h", i, words[i], exp_rx[i]);
      end
    end
    tests++;
    if (txlog.size() != exp_tx.size() || done_cyc.size() != 6) begin
      fails++;
      $display("FAIL rand_tx_count: got %0d bytes %0d dones, expected %0d bytes 6 dones",
               txlog.size(), done_cyc.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      tests++;
      if (txlog[i] !== exp_tx[i]) begin
        fails++;
        $display("FAIL rand_tx_byte[%0d]: got %h, expected %h", i, txlog[i], exp_tx[i]);
      end
    end
    tests++;
    if (to_cyc.size() != 0) begin
      fails++;
      $display("FAIL rand_no_timeout: got %0d timeouts, expected 0", to_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_rx_assembly();
    test_timeout();
    test_tx_backpressure();
    test_tx_ignore();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
